inverter_duty_seq: RTL and testbench

INVERTER_DUTY_SEQ -- requirements
Module: inverter_duty_seq

---
 rtl/inverter_duty_seq.sv | 180 ++++++++++++++++++
 tb/tb_inverter_duty_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_duty_seq.sv
// Inverter duty sequencer: soft-start/soft-stop duty ramp aligned to PWM periods, with fault latch.
// Optional build macro INVERTER_DUTY_CLAMP_EN caps accepted targets at MAX_DUTY.
module inverter_duty_seq #(
  parameter int PERIODS_PER_STEP = 4,
  parameter int MAX_DUTY         = 972
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic       period_tick,
  input  logic       tgt_valid,
  input  logic [9:0] tgt_duty,
  input  logic [3:0] step,
  output logic       tgt_ready,
  output logic [9:0] duty_cycle,
  output logic       pwm_en,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RAMP  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;
  localparam logic [7:0] PPS_C = 8'(PERIODS_PER_STEP);

  // Elaboration-time guard on parameter ranges
  if (PERIODS_PER_STEP < 1 || PERIODS_PER_STEP > 255 || MAX_DUTY < 0 || MAX_DUTY > 1023) begin : g_param_chk
    $error("inverter_duty_seq: parameter out of range");
  end

  logic [2:0]  state_r, state_n;
  logic [9:0]  duty_r, duty_n;
  logic [9:0]  tgt_r, tgt_n;
  logic [7:0]  cnt_r, cnt_n;
  logic        pwm_en_r;
  logic        tgt_ready_r;
  logic [9:0]  tgt_eff_s;
  logic        active_s;
  logic        step_ev_s;
  logic [10:0] step_amt_s;
  logic [10:0] up_s;
  logic [10:0] dn_s;
  logic [10:0] gap_s;
  logic [9:0]  ramp_duty_s;
  logic [9:0]  stop_duty_s;

`ifdef INVERTER_DUTY_CLAMP_EN
  localparam logic [9:0] MAX_DUTY_C = 10'(MAX_DUTY);
  assign tgt_eff_s = (tgt_duty > MAX_DUTY_C) ? MAX_DUTY_C : tgt_duty;
`else
  assign tgt_eff_s = tgt_duty;
`endif

  // Step-event detection and saturating ramp arithmetic (11-bit, no wrap)
  always_comb begin
    active_s   = (state_r == RAMP) || (state_r == STOP);
    step_ev_s  = active_s && period_tick && ((cnt_r + 8'd1) == PPS_C);
    step_amt_s = (step == 4'd0) ? 11'd1 : {7'd0, step};
    up_s       = {1'b0, duty_r} + step_amt_s;
    dn_s       = {1'b0, duty_r} - step_amt_s;
    gap_s      = {1'b0, duty_r} - {1'b0, tgt_r};
    if (duty_r < tgt_r) begin
      ramp_duty_s = (up_s > {1'b0, tgt_r}) ? tgt_r : up_s[9:0];
    end else if (duty_r > tgt_r) begin
      ramp_duty_s = (gap_s <= step_amt_s) ? tgt_r : dn_s[9:0];
    end else begin
      ramp_duty_s = duty_r;
    end
    if ({1'b0, duty_r} <= step_amt_s) begin
      stop_duty_s = 10'd0;
    end else begin
      stop_duty_s = dn_s[9:0];
    end
  end

  // Next-state, duty, target and period-counter decisions; fault overrides everything
  always_comb begin
    state_n = state_r;
    duty_n  = duty_r;
    tgt_n   = tgt_r;
    cnt_n   = cnt_r;
    if (fault) begin
      state_n = FAULT;
      duty_n  = 10'd0;
      tgt_n   = 10'd0;
    end else begin
      if (tgt_valid && tgt_ready_r) begin
        tgt_n = tgt_eff_s;
      end else begin
        tgt_n = tgt_r;
      end
      if (step_ev_s) begin
        cnt_n = 8'd0;
      end else if (active_s && period_tick) begin
        cnt_n = cnt_r + 8'd1;
      end else begin
        cnt_n = cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_n = RAMP;
            cnt_n   = 8'd0;
          end else begin
            state_n = IDLE;
          end
        end
        RAMP: begin
          duty_n = step_ev_s ? ramp_duty_s : duty_r;
          if (!enable) begin
            state_n = STOP;
          end else if (duty_r == tgt_r) begin
            state_n = RUN;
          end else begin
            state_n = RAMP;
          end
        end
        RUN: begin
          if (!enable) begin
            state_n = STOP;
          end else if (tgt_r != duty_r) begin
            state_n = RAMP;
          end else begin
            state_n = RUN;
          end
        end
        STOP: begin
          duty_n = step_ev_s ? stop_duty_s : duty_r;
          if (enable) begin
            state_n = RAMP;
          end else if (duty_r == 10'd0) begin
            state_n = IDLE;
          end else begin
            state_n = STOP;
          end
        end
        FAULT: begin
          if (fault_clr && !enable) begin
            state_n = IDLE;
          end else begin
            state_n = FAULT;
          end
        end
        default: begin
          state_n = FAULT;
          duty_n  = 10'd0;
          tgt_n   = 10'd0;
        end
      endcase
    end
  end

  // State and output registers; outputs are derived from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      duty_r      <= 10'd0;
      tgt_r       <= 10'd0;
      cnt_r       <= 8'd0;
      pwm_en_r    <= 1'b0;
      tgt_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      duty_r      <= duty_n;
      tgt_r       <= tgt_n;
      cnt_r       <= cnt_n;
      pwm_en_r    <= (state_n == RAMP) || (state_n == RUN) || (state_n == STOP);
      tgt_ready_r <= (state_n != FAULT);
    end
  end

  assign state      = state_r;
  assign duty_cycle = duty_r;
  assign pwm_en     = pwm_en_r;
  assign tgt_ready  = tgt_ready_r;

endmodule

// File: tb/tb_inverter_duty_seq.sv
// Bench for inverter_duty_seq: directed scenarios plus random stimulus against a behavioural model.
module tb_inverter_duty_seq;

  localparam int PPS = 4;
`ifdef INVERTER_DUTY_CLAMP_EN
  localparam int EXP_MAX = 972;
`else
  localparam int EXP_MAX = 1023;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       period_tick = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [9:0] tgt_duty = 10'd0;
  logic [3:0] step = 4'd0;
  logic       tgt_ready;
  logic [9:0] duty_cycle;
  logic       pwm_en;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail = 0;
  bit mchk_en = 1'b0;

  // Model state: plain integers, state numbers as listed in the interface table
  int m_state = 0;
  int m_duty = 0;
  int m_tgt = 0;
  int m_cnt = 0;

  inverter_duty_seq #(.PERIODS_PER_STEP(PPS), .MAX_DUTY(972)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fault(fault), .fault_clr(fault_clr),
    .period_tick(period_tick), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty), .step(step),
    .tgt_ready(tgt_ready), .duty_cycle(duty_cycle), .pwm_en(pwm_en), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f_clamp(input int v);
`ifdef INVERTER_DUTY_CLAMP_EN
    return (v > 972) ? 972 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit f_ev(input int st, input int cnt, input bit tick);
    return (st == 1 || st == 3) && tick && (cnt + 1 == PPS);
  endfunction

  function automatic int f_duty(input int st, input int d, input int t, input int s, input bit ev);
    int amt;
    amt = (s == 0) ? 1 : s;
    if (!ev) return d;
    if (st == 1) begin
      if (d < t) return (d + amt < t) ? d + amt : t;
      if (d > t) return (d - amt > t) ? d - amt : t;
      return d;
    end
    if (st == 3) return (d > amt) ? d - amt : 0;
    return d;
  endfunction

  function automatic int f_cnt(input int st, input int cnt, input bit tick, input bit en);
    if (st == 0) return en ? 0 : cnt;
    if (f_ev(st, cnt, tick)) return 0;
    if ((st == 1 || st == 3) && tick) return cnt + 1;
    return cnt;
  endfunction

  function automatic int f_next(input int st, input int d, input int t, input bit en, input bit clr);
    case (st)
      0: return en ? 1 : 0;
      1: return !en ? 3 : ((d == t) ? 2 : 1);
      2: return !en ? 3 : ((d != t) ? 1 : 2);
      3: return en ? 1 : ((d == 0) ? 0 : 3);
      4: return (clr && !en) ? 0 : 4;
      default: return 4;
    endcase
  endfunction

  // Reference model advances on the same edge as the design
  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0; m_duty <= 0; m_tgt <= 0; m_cnt <= 0;
    end else if (fault) begin
      m_state <= 4; m_duty <= 0; m_tgt <= 0;
    end else begin
      m_cnt   <= f_cnt(m_state, m_cnt, period_tick, enable);
      m_duty  <= f_duty(m_state, m_duty, m_tgt, int'(step), f_ev(m_state, m_cnt, period_tick));
      m_state <= f_next(m_state, m_duty, m_tgt, enable, fault_clr);
      if (tgt_valid && m_state != 4) m_tgt <= f_clamp(int'(tgt_duty));
    end
  end

  // Continuous comparison of all outputs against the model
  always @(negedge clk) begin
    if (mchk_en) begin
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_duty", 32'(duty_cycle), 32'(m_duty));
      chk("model_pwm_en", 32'(pwm_en), 32'((m_state >= 1 && m_state <= 3) ? 1 : 0));
      chk("model_tgt_ready", 32'(tgt_ready), 32'((m_state != 4) ? 1 : 0));
    end
  end

  // One full step event: PPS ticks spaced by gap; returns on the negedge right after the last tick
  task automatic ev_tick(input int gap);
    for (int i = 0; i < PPS; i++) begin
      period_tick = 1'b1;
      @(negedge clk);
      period_tick = 1'b0;
      if (i != PPS - 1) repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic offer(input int t, input int s);
    tgt_valid = 1'b1;
    tgt_duty = 10'(t);
    step = 4'(s);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_duty", 32'(duty_cycle), 32'd0);
    chk("reset_pwm_en", 32'(pwm_en), 32'd0);
    chk("reset_tgt_ready", 32'(tgt_ready), 32'd1);
    reset = 1'b0;
    mchk_en = 1'b1;

    // Soft start to 100 in steps of 10, tick every 8 cycles
    enable = 1'b1;
    offer(100, 10);
    chk("ss_enter_ramp", 32'(state), 32'd1);
    chk("ss_pwm_en", 32'(pwm_en), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      ev_tick(8);
      chk("ss_duty", 32'(duty_cycle), 32'(10 * k));
      repeat (7) @(negedge clk);
    end
    chk("ss_run", 32'(state), 32'd2);

    // Retarget down to 40 with step 15
    offer(40, 15);
    @(negedge clk);
    chk("rt_ramp", 32'(state), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      ev_tick(2);
      chk("rt_duty", 32'(duty_cycle), 32'(100 - 15 * k));
      @(negedge clk);
    end
    chk("rt_run", 32'(state), 32'd2);

    // Reach 30, then soft stop with step 0 (treated as 1)
    offer(30, 10);
    @(negedge clk);
    ev_tick(2);
    chk("st_duty30", 32'(duty_cycle), 32'd30);
    repeat (2) @(negedge clk);
    chk("st_run30", 32'(state), 32'd2);
    enable = 1'b0;
    step = 4'd0;
    @(negedge clk);
    chk("st_stop", 32'(state), 32'd3);
    for (int k = 1; k <= 30; k++) begin
      ev_tick(2);
      chk("st_duty", 32'(duty_cycle), 32'(30 - k));
      @(negedge clk);
    end
    chk("st_idle", 32'(state), 32'd0);
    chk("st_pwm_off", 32'(pwm_en), 32'd0);

    // Non-multiple target: 10, 20, 25
    enable = 1'b1;
    offer(25, 10);
    for (int k = 1; k <= 3; k++) begin
      ev_tick(2);
      chk("nm_duty", 32'(duty_cycle), 32'((k == 3) ? 25 : 10 * k));
      @(negedge clk);
    end
    chk("nm_run", 32'(state), 32'd2);

    // Fault mid-ramp at 60
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    offer(100, 10);
    for (int k = 1; k <= 6; k++) ev_tick(2);
    chk("ft_duty60", 32'(duty_cycle), 32'd60);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("ft_state", 32'(state), 32'd4);
    chk("ft_duty", 32'(duty_cycle), 32'd0);
    chk("ft_pwm", 32'(pwm_en), 32'd0);
    chk("ft_ready", 32'(tgt_ready), 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    chk("ft_clr_enabled", 32'(state), 32'd4);
    fault_clr = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("ft_no_clr", 32'(state), 32'd4);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("ft_cleared", 32'(state), 32'd0);

    // Reset wins over fault
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    fault = 1'b1;
    @(negedge clk);
    chk("rst_prio_state", 32'(state), 32'd0);
    chk("rst_prio_ready", 32'(tgt_ready), 32'd1);
    reset = 1'b0;
    fault = 1'b0;

    // Full-scale target: clamped or not depending on build
    offer(1023, 15);
    for (int k = 0; k < 100 && state != 3'd2; k++) begin
      ev_tick(2);
      @(negedge clk);
    end
    chk("cl_state", 32'(state), 32'd2);
    chk("cl_duty", 32'(duty_cycle), 32'(EXP_MAX));

    // Random stimulus against the model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      fault = ($urandom_range(0, 99) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      period_tick = ($urandom_range(0, 2) == 0);
      tgt_valid = ($urandom_range(0, 19) == 0);
      tgt_duty = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom);
      step = 4'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    mchk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
